stream_mux: RTL and testbench

Parametrised N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshakes on every input channel and on the output. It runs in one of two modes: explicit select, with the same channel numbering and zero-default behaviour as the plain datapath muxes, or fair round-robin arbitration. It sits between multiple producers (e.g. fetch/LSU/DMA request paths) and a single downstream consumer such as the bus interface. It provides one output register stage with full one-transfer-per-cycle throughput.

---
 rtl/stream_mux.sv | 129 ++++++++++++
 tb/tb_stream_mux.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux.sv
// stream_mux: N-channel registered stream multiplexer.
// Channels are picked by an explicit select (mode 0) or by fair round-robin (mode 1).
// The single output register stage sustains one transfer per cycle.
module stream_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 3,
    parameter int SELW  = 2
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_mode,
    input  logic [SELW-1:0]    I_sel,
    input  logic [N-1:0]       I_valid,
    input  logic [N*WIDTH-1:0] I_data,
    output logic [N-1:0]       O_ready,
    output logic               O_valid,
    output logic [WIDTH-1:0]   O_data,
    output logic [SELW-1:0]    O_chan,
    input  logic               I_ready
);

    // Output register and round-robin pointer
    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic [SELW-1:0]  chan_r;
    logic [SELW-1:0]  ptr_r;

    // Arbitration signals
    logic             load_s;
    logic [N-1:0]     sel_hit_s;
    logic [N-1:0]     rr_hi_s;
    logic [N-1:0]     rr_lo_s;
    logic             grant_s;
    logic [SELW-1:0]  gidx_s;
    logic [WIDTH-1:0] gdata_s;
    logic [SELW-1:0]  ptr_nxt_s;
    logic [N-1:0]     ready_s;

    // Lowest set bit index of a request mask (0 when the mask is empty).
    function automatic logic [SELW-1:0] first_idx(input logic [N-1:0] m);
        logic [SELW-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            r = m[i] ? SELW'(i) : r;
        end
        return r;
    endfunction

    // The slot can take a new beat when empty or being drained this cycle
    assign load_s = !valid_r || I_ready;

    // Per-channel request masks; out-of-range selects match no channel.
    // Round-robin splits requests into those at/after the pointer and those before it,
    // so the first one at/after the pointer wins and otherwise the search wraps.
    always_comb begin
        sel_hit_s = '0;
        rr_hi_s   = '0;
        rr_lo_s   = '0;
        for (int i = 0; i < N; i++) begin
            sel_hit_s[i] = I_valid[i] && (I_sel == SELW'(i));
            rr_hi_s[i]   = I_valid[i] && (SELW'(i) >= ptr_r);
            rr_lo_s[i]   = I_valid[i] && (SELW'(i) < ptr_r);
        end
    end

    // Grant selection for the active mode
    always_comb begin
        grant_s = 1'b0;
        gidx_s  = '0;
        if (I_mode == 1'b0) begin
            grant_s = |sel_hit_s;
            gidx_s  = first_idx(sel_hit_s);
        end else if (|rr_hi_s) begin
            grant_s = 1'b1;
            gidx_s  = first_idx(rr_hi_s);
        end else begin
            grant_s = |rr_lo_s;
            gidx_s  = first_idx(rr_lo_s);
        end
    end

    // Data of the granted channel and per-channel accept strobes
    always_comb begin
        gdata_s = '0;
        ready_s = '0;
        for (int i = 0; i < N; i++) begin
            gdata_s    = (gidx_s == SELW'(i)) ? I_data[i*WIDTH +: WIDTH] : gdata_s;
            ready_s[i] = !I_rst && grant_s && load_s && (gidx_s == SELW'(i));
        end
    end

    // Pointer moves just past the granted channel, wrapping after N-1
    assign ptr_nxt_s = (gidx_s == SELW'(N - 1)) ? '0 : gidx_s + SELW'(1);

    // Output register load/clear/hold and pointer update
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
            chan_r  <= '0;
            ptr_r   <= '0;
        end else if (load_s) begin
            if (grant_s) begin
                valid_r <= 1'b1;
                data_r  <= gdata_s;
                chan_r  <= gidx_s;
                if (I_mode == 1'b1) begin
                    ptr_r <= ptr_nxt_s;
                end else begin
                    ptr_r <= ptr_r;
                end
            end else begin
                valid_r <= 1'b0;
                data_r  <= '0;
                chan_r  <= '0;
            end
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
            chan_r  <= chan_r;
        end
    end

    assign O_ready = ready_s;
    assign O_valid = valid_r;
    assign O_data  = data_r;
    assign O_chan  = chan_r;

endmodule

// File: tb/tb_stream_mux.sv
// Testbench for stream_mux: directed vectors, expected beats queued by the
// stimulus and checked by an independent output monitor.
module tb_stream_mux;

    localparam int W    = 32;
    localparam int N    = 3;
    localparam int SELW = 2;

    typedef struct {
        logic [W-1:0]    data;
        logic [SELW-1:0] chan;
    } beat_t;

    logic            I_clk = 1'b0;
    logic            I_rst;
    logic            I_mode;
    logic [SELW-1:0] I_sel;
    logic [N-1:0]    I_valid;
    logic [W-1:0]    d [N];
    logic [N*W-1:0]  I_data;
    logic [N-1:0]    O_ready;
    logic            O_valid;
    logic [W-1:0]    O_data;
    logic [SELW-1:0] O_chan;
    logic            I_ready;

    beat_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    assign I_data = {d[2], d[1], d[0]};

    always #5 I_clk = ~I_clk;

    stream_mux #(.WIDTH(W), .N(N), .SELW(SELW)) dut (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .I_mode  (I_mode),
        .I_sel   (I_sel),
        .I_valid (I_valid),
        .I_data  (I_data),
        .O_ready (O_ready),
        .O_valid (O_valid),
        .O_data  (O_data),
        .O_chan  (O_chan),
        .I_ready (I_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [W-1:0] data, input logic [SELW-1:0] chan);
        beat_t b;
        b.data = data;
        b.chan = chan;
        sb_q.push_back(b);
    endtask

    task automatic cyc();
        @(posedge I_clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [W-1:0] dat, input logic [SELW-1:0] ch);
        chk({name, "_valid"}, 64'(O_valid), 64'(v));
        chk({name, "_data"},  64'(O_data),  64'(dat));
        chk({name, "_chan"},  64'(O_chan),  64'(ch));
    endtask

    // Monitor: every beat taken downstream must match the oldest expected beat
    always @(negedge I_clk) begin
        if (!I_rst && O_valid && I_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got data %0h chan %0d, expected none", O_data, O_chan);
            end else begin
                beat_t e;
                e = sb_q.pop_front();
                chk("beat_data", 64'(O_data), 64'(e.data));
                chk("beat_chan", 64'(O_chan), 64'(e.chan));
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        I_rst   = 1'b1;
        I_mode  = 1'b1;
        I_sel   = 2'd0;
        I_valid = 3'b111;
        I_ready = 1'b1;
        d[0]    = 32'h0000_0010;
        d[1]    = 32'h0000_0011;
        d[2]    = 32'h0000_0012;

        // Reset held with all channels requesting: nothing accepted, register clear
        repeat (2) begin
            @(negedge I_clk);
            chk("rst_ready", 64'(O_ready), 64'(3'b000));
            chk_out("rst", 1'b0, 32'h0, 2'd0);
        end
        cyc();
        I_rst = 1'b0;

        // Round-robin, all valid: 0,1,2,0,1,2,0 back to back
        for (int k = 0; k < 7; k++) begin
            @(negedge I_clk);
            chk("rr_ready", 64'(O_ready), 64'(3'b001 << (k % 3)));
            if (k > 0) chk("rr_nobubble", 64'(O_valid), 64'(1'b1));
            push(32'h10 + 32'(k % 3), 2'(k % 3));
            cyc();
        end

        // Only ch0 and ch2 requesting; pointer sits at 1 so ch2 comes first
        I_valid = 3'b101;
        for (int k = 0; k < 4; k++) begin
            @(negedge I_clk);
            if (k % 2 == 0) begin
                chk("alt_ready", 64'(O_ready), 64'(3'b100));
                push(32'h12, 2'd2);
            end else begin
                chk("alt_ready", 64'(O_ready), 64'(3'b001));
                push(32'h10, 2'd0);
            end
            cyc();
        end

        // Explicit select of ch1
        I_mode  = 1'b0;
        I_sel   = 2'd1;
        I_valid = 3'b111;
        d[1]    = 32'hDEAD_BEEF;
        @(negedge I_clk);
        chk("sel1_ready", 64'(O_ready), 64'(3'b010));
        push(32'hDEAD_BEEF, 2'd1);
        cyc();
        // Out-of-range select: no accept, beat drains and register clears
        I_sel = 2'd3;
        @(negedge I_clk);
        chk("sel3_ready", 64'(O_ready), 64'(3'b000));
        chk_out("sel1_beat", 1'b1, 32'hDEAD_BEEF, 2'd1);
        cyc();
        @(negedge I_clk);
        chk("sel3_ready2", 64'(O_ready), 64'(3'b000));
        chk_out("sel3_clear", 1'b0, 32'h0, 2'd0);
        cyc();

        // Backpressure: load 0xA5A5A5A5 from ch0 then stall for 4 cycles
        I_sel = 2'd0;
        d[0]  = 32'hA5A5_A5A5;
        @(negedge I_clk);
        chk("bp_load_ready", 64'(O_ready), 64'(3'b001));
        push(32'hA5A5_A5A5, 2'd0);
        cyc();
        I_ready = 1'b0;
        I_mode  = 1'b1;
        I_valid = 3'b100;
        d[2]    = 32'hC2C2_C2C2;
        repeat (4) begin
            @(negedge I_clk);
            chk("bp_ready", 64'(O_ready), 64'(3'b000));
            chk_out("bp_hold", 1'b1, 32'hA5A5_A5A5, 2'd0);
            cyc();
        end
        // Release: ch2 granted in the same cycle the stalled beat drains
        I_ready = 1'b1;
        @(negedge I_clk);
        chk("bp_release_ready", 64'(O_ready), 64'(3'b100));
        push(32'hC2C2_C2C2, 2'd2);
        cyc();
        // Pointer now 0: ch0 next, leaving pointer at 1
        I_valid = 3'b001;
        d[0]    = 32'h0000_0010;
        @(negedge I_clk);
        chk_out("bp_ch2_beat", 1'b1, 32'hC2C2_C2C2, 2'd2);
        chk("pre_rst_ready", 64'(O_ready), 64'(3'b001));
        push(32'h10, 2'd0);
        cyc();

        // Stall the ch0 beat, then reset mid-stream
        I_ready = 1'b0;
        I_valid = 3'b000;
        @(negedge I_clk);
        chk_out("pre_rst_hold", 1'b1, 32'h10, 2'd0);
        cyc();
        I_rst   = 1'b1;
        I_valid = 3'b111;
        @(negedge I_clk);
        chk("rst_mid_ready", 64'(O_ready), 64'(3'b000));
        cyc();
        // Stalled beat is dropped, never delivered
        void'(sb_q.pop_back());
        I_rst   = 1'b0;
        I_ready = 1'b1;
        I_mode  = 1'b1;
        @(negedge I_clk);
        chk_out("post_rst", 1'b0, 32'h0, 2'd0);
        chk("post_rst_ptr0", 64'(O_ready), 64'(3'b001));
        push(32'h10, 2'd0);
        cyc();
        I_valid = 3'b000;
        @(negedge I_clk);
        chk_out("post_rst_beat", 1'b1, 32'h10, 2'd0);
        cyc();
        @(negedge I_clk);
        chk_out("no_replay", 1'b0, 32'h0, 2'd0);
        cyc();
        @(negedge I_clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
